// File: rtl/function_eval_pkg.sv
`default_nettype none
// ============================================================================
// Module : function_eval_pkg
// Brief  : Shared opcodes, default widths and sequencer state encoding
// Rev    : 1.0  initial release
// ============================================================================
package function_eval_pkg;

    localparam int DEF_FLT_DATA_WIDTH = 32;
    localparam int DEF_N_WIDTH        = 2;

    localparam logic [DEF_N_WIDTH-1:0] OP_CLEAR = 2'd0;
    localparam logic [DEF_N_WIDTH-1:0] OP_GO    = 2'd1;
    localparam logic [DEF_N_WIDTH-1:0] OP_READ  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_GAP    = 3'd3,
        S_REPORT = 3'd4
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/operand_fifo.sv
`default_nettype none
// ============================================================================
// Module : operand_fifo
// Brief  : Synchronous operand-pair FIFO with occupancy count and bulk drop
// Rev    : 1.0  initial release
// ============================================================================
module operand_fifo #(
    parameter int  WIDTH = 64,
    parameter int  DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             drop_i,
    input  logic [CNT_W-1:0] drop_cnt_i,
    output logic             full_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] w_rd_adv;
    logic             w_push_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Full is judged on the current count, so a same-cycle pop never frees a slot early.
    always_comb begin
        w_push_ok = push_i && !full_o;
        w_rd_adv  = '0;
        if (drop_i) begin
            w_rd_adv = drop_cnt_i;
        end else if (pop_i && (count_q != '0)) begin
            w_rd_adv = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q <= rd_ptr_q + PTR_W'(w_rd_adv);
            count_q  <= count_q + CNT_W'(w_push_ok) - w_rd_adv;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/function_eval_sequencer.sv
`default_nettype none
// ============================================================================
// Module : function_eval_sequencer
// Brief  : Buffers operand pairs and drives one CLEAR/GO.../READ evaluator batch
// Rev    : 1.0  initial release
// ============================================================================
module function_eval_sequencer
    import function_eval_pkg::*;
#(
    parameter int FLT_DATA_WIDTH = DEF_FLT_DATA_WIDTH,
    parameter int N_WIDTH        = DEF_N_WIDTH,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [FLT_DATA_WIDTH-1:0] push_x_one,
    input  logic [FLT_DATA_WIDTH-1:0] push_x_two,
    output logic                      full,
    input  logic                      run,
    output logic                      busy,
    output logic [FLT_DATA_WIDTH-1:0] result,
    output logic                      result_valid,
    output logic                      error,
    output logic                      ci_clk_en,
    output logic                      ci_start,
    output logic [N_WIDTH-1:0]        ci_n,
    output logic [FLT_DATA_WIDTH-1:0] ci_x_one,
    output logic [FLT_DATA_WIDTH-1:0] ci_x_two,
    input  logic                      ci_done,
    input  logic [FLT_DATA_WIDTH-1:0] ci_result
);

    localparam int                 CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int                 TMO_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [N_WIDTH-1:0] OPC_CLEAR = N_WIDTH'(OP_CLEAR);
    localparam logic [N_WIDTH-1:0] OPC_GO    = N_WIDTH'(OP_GO);
    localparam logic [N_WIDTH-1:0] OPC_READ  = N_WIDTH'(OP_READ);

    seq_state_e                  state_q;
    logic [CNT_W-1:0]            remaining_q;
    logic [TMO_W-1:0]            tmo_q;
    logic [FLT_DATA_WIDTH-1:0]   rd_data_q;
    logic [FLT_DATA_WIDTH-1:0]   result_q;
    logic                        result_valid_q;
    logic                        error_q;
    logic                        busy_q;
    logic                        ci_start_q;
    logic [N_WIDTH-1:0]          ci_n_q;
    logic [FLT_DATA_WIDTH-1:0]   ci_x_one_q;
    logic [FLT_DATA_WIDTH-1:0]   ci_x_two_q;
    logic [CNT_W-1:0]            w_fifo_count;
    logic [2*FLT_DATA_WIDTH-1:0] w_fifo_rdata;
    logic                        w_pop;
    logic                        w_timeout;

    // The head pair is popped on the edge that enters ISSUE, so it is on the bus during ISSUE.
    assign w_pop     = (state_q == S_GAP) && (ci_n_q != OPC_READ) && (remaining_q != '0);
    assign w_timeout = (state_q == S_WAIT) && !ci_done && (tmo_q == TMO_LAST);

    operand_fifo #(
        .WIDTH (2 * FLT_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .wdata_i    ({push_x_one, push_x_two}),
        .pop_i      (w_pop),
        .drop_i     (w_timeout),
        .drop_cnt_i (remaining_q),
        .full_o     (full),
        .rdata_o    (w_fifo_rdata),
        .count_o    (w_fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            remaining_q    <= '0;
            tmo_q          <= '0;
            rd_data_q      <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
            busy_q         <= 1'b0;
            ci_start_q     <= 1'b0;
            ci_n_q         <= '0;
            ci_x_one_q     <= '0;
            ci_x_two_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q     <= S_ISSUE;
                        busy_q      <= 1'b1;
                        ci_start_q  <= 1'b1;
                        ci_n_q      <= OPC_CLEAR;
                        ci_x_one_q  <= '0;
                        ci_x_two_q  <= '0;
                        remaining_q <= w_fifo_count;
                    end
                end
                S_ISSUE: begin
                    ci_start_q <= 1'b0;
                    tmo_q      <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (ci_done) begin
                        state_q <= S_GAP;
                        if (ci_n_q == OPC_READ) begin
                            rd_data_q <= ci_result;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        remaining_q    <= '0;
                        result_q       <= '0;
                        error_q        <= 1'b1;
                        result_valid_q <= 1'b1;
                        state_q        <= S_REPORT;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                S_GAP: begin
                    if (ci_n_q == OPC_READ) begin
                        result_q       <= rd_data_q;
                        error_q        <= 1'b0;
                        result_valid_q <= 1'b1;
                        state_q        <= S_REPORT;
                    end else begin
                        ci_start_q <= 1'b1;
                        state_q    <= S_ISSUE;
                        if (remaining_q != '0) begin
                            ci_n_q      <= OPC_GO;
                            ci_x_one_q  <= w_fifo_rdata[2*FLT_DATA_WIDTH-1:FLT_DATA_WIDTH];
                            ci_x_two_q  <= w_fifo_rdata[FLT_DATA_WIDTH-1:0];
                            remaining_q <= remaining_q - CNT_W'(1);
                        end else begin
                            ci_n_q     <= OPC_READ;
                            ci_x_one_q <= '0;
                            ci_x_two_q <= '0;
                        end
                    end
                end
                S_REPORT: begin
                    result_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                    ci_n_q         <= '0;
                    ci_x_one_q     <= '0;
                    ci_x_two_q     <= '0;
                    state_q        <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign ci_clk_en    = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;
    assign ci_start     = ci_start_q;
    assign ci_n         = ci_n_q;
    assign ci_x_one     = ci_x_one_q;
    assign ci_x_two     = ci_x_two_q;

endmodule
`default_nettype wire

// File: tb/tb_function_eval_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_function_eval_sequencer
// Brief  : Scoreboard bench with a fixed-latency evaluator responder
// Rev    : 1.0  initial release
// ============================================================================
module tb_function_eval_sequencer;

    localparam int W     = 32;
    localparam int NW    = 2;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;
    localparam int LAT   = 3;

    typedef struct {
        logic [NW-1:0] op;
        logic [W-1:0]  x1;
        logic [W-1:0]  x2;
    } ins_t;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           at;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic [W-1:0]  push_x_one;
    logic [W-1:0]  push_x_two;
    logic          full;
    logic          run;
    logic          busy;
    logic [W-1:0]  result;
    logic          result_valid;
    logic          error;
    logic          ci_clk_en;
    logic          ci_start;
    logic [NW-1:0] ci_n;
    logic [W-1:0]  ci_x_one;
    logic [W-1:0]  ci_x_two;
    logic          ci_done;
    logic [W-1:0]  ci_result;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            hang_go = 0;
    logic [W-1:0]  resp_val;
    ins_t          exp_ins[$];
    res_t          exp_res[$];
    logic [2*W-1:0] model_q[$];

    function_eval_sequencer #(
        .FLT_DATA_WIDTH (W),
        .N_WIDTH        (NW),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_x_one   (push_x_one),
        .push_x_two   (push_x_two),
        .full         (full),
        .run          (run),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .error        (error),
        .ci_clk_en    (ci_clk_en),
        .ci_start     (ci_start),
        .ci_n         (ci_n),
        .ci_x_one     (ci_x_one),
        .ci_x_two     (ci_x_two),
        .ci_done      (ci_done),
        .ci_result    (ci_result)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Evaluator: ci_done is captured by the DUT LAT edges after the edge launching ci_start.
    initial begin
        int go_cnt;
        go_cnt    = 0;
        ci_done   = 1'b0;
        ci_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ci_start && !rst) begin
                if (ci_n == 2'd0) go_cnt = 0;
                if (ci_n == 2'd1) go_cnt++;
                if (!(ci_n == 2'd1 && go_cnt == hang_go)) begin
                    repeat (LAT - 1) @(posedge clk);
                    #1;
                    ci_done   = 1'b1;
                    ci_result = (ci_n == 2'd2) ? resp_val : W'($urandom());
                    @(posedge clk);
                    #1;
                    ci_done = 1'b0;
                end
            end
        end
    end

    initial begin
        ins_t ei;
        res_t er;
        forever begin
            @(negedge clk);
            if (!rst && ci_start) begin
                if (exp_ins.size() == 0) begin
                    check("spurious_ci_start", 64'(ci_start), 64'd0);
                end else begin
                    ei = exp_ins.pop_front();
                    check("ci_n", 64'(ci_n), 64'(ei.op));
                    if (ei.op == 2'd1) begin
                        check("ci_x_one", 64'(ci_x_one), 64'(ei.x1));
                        check("ci_x_two", 64'(ci_x_two), 64'(ei.x2));
                    end
                end
            end
            if (!rst && result_valid) begin
                if (exp_res.size() == 0) begin
                    check("spurious_result_valid", 64'(result_valid), 64'd0);
                end else begin
                    er = exp_res.pop_front();
                    check("result", 64'(result), 64'(er.res));
                    check("error", 64'(error), 64'(er.err));
                    check("result_cycle", 64'(cyc), 64'(er.at));
                end
            end
        end
    end

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b, input bit chk_full);
        @(posedge clk);
        #1;
        push       = 1'b1;
        push_x_one = a;
        push_x_two = b;
        if (model_q.size() < DEPTH) model_q.push_back({a, b});
        @(posedge clk);
        #1;
        push = 1'b0;
        if (chk_full) check("full", 64'(full), 64'(model_q.size() == DEPTH));
    endtask

    // hang > 0 names the GO (1-based) that the evaluator never completes.
    task automatic do_run(input int hang);
        int k;
        int n;
        int t;
        logic [2*W-1:0] p;
        k = model_q.size();
        hang_go = hang;
        @(posedge clk);
        #1;
        run = 1'b1;
        t = cyc;
        exp_ins.push_back(ins_t'{2'd0, '0, '0});
        n = (hang > 0 && hang <= k) ? hang : k;
        for (int i = 0; i < n; i++) begin
            p = model_q.pop_front();
            exp_ins.push_back(ins_t'{2'd1, p[2*W-1:W], p[W-1:0]});
        end
        if (hang > 0 && hang <= k) begin
            model_q.delete();
            exp_res.push_back(res_t'{'0, 1'b1, t + 1 + hang * (LAT + 1) + TMO + 1});
        end else begin
            exp_ins.push_back(ins_t'{2'd2, '0, '0});
            exp_res.push_back(res_t'{resp_val, 1'b0, t + 1 + (k + 2) * (LAT + 1)});
        end
        @(posedge clk);
        #1;
        run = 1'b0;
    endtask

    task automatic pulse_run();
        @(posedge clk);
        #1;
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((busy || exp_res.size() != 0) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("batch_completes", 64'(n < 400), 64'd1);
        check("all_instructions_seen", 64'(exp_ins.size()), 64'd0);
        hang_go = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 64'({busy, ci_clk_en, ci_start, ci_n, result_valid, error, full}), 64'd0);
        check({tag, "_operands"}, {ci_x_one, ci_x_two}, 64'd0);
        check({tag, "_result"}, 64'(result), 64'd0);
    endtask

    initial begin
        int n;
        int k;
        rst        = 1'b1;
        push       = 1'b0;
        run        = 1'b0;
        push_x_one = '0;
        push_x_two = '0;
        resp_val   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Two-pair batch with known operands and READ value
        resp_val = 32'h1234_5678;
        push_pair(32'h3F80_0000, 32'h4000_0000, 1'b1);
        push_pair(32'h4040_0000, 32'h4080_0000, 1'b1);
        do_run(0);
        wait_done();

        // Empty batch
        resp_val = 32'hCAFE_0001;
        do_run(0);
        wait_done();

        // Overfill: the ninth pair is dropped
        resp_val = 32'h0BAD_F00D;
        for (int i = 0; i < 9; i++) push_pair(W'($urandom()), W'($urandom()), 1'b1);
        do_run(0);
        wait_done();

        // Evaluator hangs on the second GO
        for (int i = 0; i < 3; i++) push_pair(W'($urandom()), W'($urandom()), 1'b1);
        do_run(2);
        wait_done();
        check("full_after_abort", 64'(full), 64'd0);
        resp_val = 32'h5555_AAAA;
        do_run(0);
        wait_done();

        // Late push and ignored run during a batch
        resp_val = 32'h0F0F_1234;
        push_pair(W'($urandom()), W'($urandom()), 1'b1);
        push_pair(W'($urandom()), W'($urandom()), 1'b1);
        do_run(0);
        repeat (4) @(posedge clk);
        push_pair(W'($urandom()), W'($urandom()), 1'b0);
        pulse_run();
        wait_done();
        resp_val = 32'h7777_0000;
        do_run(0);
        wait_done();

        // Asynchronous reset during the WAIT of a GO
        push_pair(W'($urandom()), W'($urandom()), 1'b1);
        push_pair(W'($urandom()), W'($urandom()), 1'b1);
        do_run(0);
        n = 0;
        while (!(ci_start && ci_n == 2'd1) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached_go", 64'(n < 100), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midbatch_reset");
        exp_ins.delete();
        exp_res.delete();
        model_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        resp_val = 32'hDEAD_BEEF;
        push_pair(W'($urandom()), W'($urandom()), 1'b1);
        do_run(0);
        wait_done();

        // Randomized batches
        for (int b = 0; b < 5; b++) begin
            k = $urandom_range(0, DEPTH);
            resp_val = W'($urandom());
            for (int i = 0; i < k; i++) push_pair(W'($urandom()), W'($urandom()), 1'b1);
            do_run(0);
            wait_done();
        end

        check("final_idle", 64'({busy, ci_clk_en}), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/function_eval_sequencer.md
# function_eval_sequencer

Initiator side of the function-evaluation custom-instruction handshake. Buffers operand pairs written by a host, then drives the evaluator through one complete batch: CLEAR, one GO per buffered pair, and a final READ. The READ result is returned to the host. It sits between the host/DMA logic and the evaluator, replacing hand-sequenced software custom-instruction calls.

## Interface
- FLT_DATA_WIDTH, 32, operand/result width (IEEE-754 single)
- N_WIDTH, 2, opcode width
- FIFO_DEPTH, 8, operand-pair buffer depth (power of two, ≥2)
- TIMEOUT_CYCLES, 1024, max cycles from ci_start to ci_done before abort

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- push  in  1  write {push_x_one, push_x_two} into buffer
- push_x_one  in  FLT_DATA_WIDTH  first operand
- push_x_two  in  FLT_DATA_WIDTH  second operand
- full  out  1  buffer full; push ignored
- run  in  1  start a batch (accepted only when busy=0)
- busy  out  1  batch in progress
- result  out  FLT_DATA_WIDTH  batch result, held until the next batch's result_valid
- result_valid  out  1  one-cycle pulse, result/error valid
- error  out  1  last batch aborted on timeout; updated with result_valid
- ci_clk_en  out  1  evaluator clock enable
- ci_start  out  1  one-cycle instruction start
- ci_n  out  N_WIDTH  opcode: CLEAR=0, GO=1, READ=2
- ci_x_one, ci_x_two  out  FLT_DATA_WIDTH  operands
- ci_done  in  1  evaluator completion pulse
- ci_result  in  FLT_DATA_WIDTH  evaluator result, sampled on ci_done

## Operation
- States: IDLE, ISSUE, WAIT, GAP, REPORT.
- run in IDLE:
  - latch batch_count = current buffer occupancy (0..FIFO_DEPTH);
  - set op = CLEAR; go to ISSUE.
  - Pairs pushed after run belong to the next batch.
- ISSUE, one cycle:
  - ci_start=1, ci_n=op.
  - For GO, pop the head pair onto ci_x_one/ci_x_two and decrement the remaining count.
  - Go to WAIT; start timeout counter at 0.
- WAIT: ci_start=0; ci_n and operands held stable.
  - On ci_done: go to GAP. On READ, capture ci_result.
  - If the counter reaches TIMEOUT_CYCLES-1 without ci_done: error=1, discard unissued pairs of this batch, result=0, go to REPORT.
- GAP, one cycle, ci_start=0. Next op:
  - after CLEAR, GO if remaining>0, else READ;
  - after GO, GO if remaining>0, else READ;
  - after READ, REPORT.
  - GAP then returns to ISSUE, except after READ.
- REPORT: result_valid=1 for one cycle; error=0 unless timeout; go to IDLE.
- ci_clk_en=1 whenever busy=1, and also during REPORT; 0 in IDLE.
- busy=1 in every state except IDLE.
- Buffer behaviour:
  - push when full is dropped.
  - push and pop in the same cycle are both performed when not full.
  - While full, push is dropped even if a pop occurs that cycle.
- Zero-pair batch: CLEAR then READ.

## Timing
- Reset values: all outputs 0, buffer empty, state IDLE.
- run at cycle t gives ci_start at t+1.
- Each instruction costs responder latency L (ci_start to ci_done, L≥1) plus one GAP cycle.
- Batch of k pairs: result_valid at t+1+(k+2)(L+1), counting from the ISSUE of CLEAR.
- ci_done outside WAIT is ignored.
- ci_done in the same cycle as the timeout terminal count counts as success.
- run while busy is ignored.
- Reset mid-batch: immediate return to reset values. No READ is issued; the evaluator must be re-cleared by the next batch, which always begins with CLEAR.

## Structure
- Shared package function_eval_pkg:
  - opcode constants CLEAR/GO/READ;
  - FLT_DATA_WIDTH and N_WIDTH defaults;
  - state encoding constants.
- One sub-module, operand_fifo: synchronous FIFO of 2·FLT_DATA_WIDTH bits with full/empty/count and async active-high reset. Sequencer FSM and timeout counter live in the top.

## Test plan
- Responder model with L=3. Push pairs (0x3F800000, 0x40000000) and (0x40400000, 0x40800000), then run → opcode sequence 0,1,1,2. GO operands are presented in push order. result_valid at t+1+4·4, carrying the responder's READ value 0x12345678; error=0.
- run with empty buffer → CLEAR then READ only; result_valid at t+9.
- Push 9 pairs with FIFO_DEPTH=8 → full high after the 8th; the 9th is dropped; the batch issues exactly 8 GOs.
- Responder never asserts ci_done on the 2nd GO; TIMEOUT_CYCLES=16 → abort 16 cycles after that ci_start. No further ci_start; result_valid with error=1, result=0. Remaining pairs discarded; buffer empty.
- Push during WAIT of a 2-pair batch → batch still issues 2 GOs. A second run then issues 1 GO with the late pair.
- Assert rst during WAIT of a GO → all outputs 0 at once. Buffer empty. The next run starts with CLEAR.
